// File: rtl/f1_sequencer_if.sv
// f1_sequencer_if: start button, tick and delay-stage signals of the start-light sequencer
interface f1_sequencer_if;
   logic        tick;
   logic        start;
   logic        time_out;
   logic        trigger;
   logic [15:0] N;
   logic [9:0]  ledr;
   logic        busy;
   modport master (output tick, start, time_out, input trigger, N, ledr, busy);
   modport slave  (input tick, start, time_out, output trigger, N, ledr, busy);
endinterface

// File: rtl/f1_sequencer.sv
// f1_sequencer: lights ten LEDs at a tick-based pace, then holds trigger until the delay stage times out
module f1_sequencer #(
   parameter int STEP_TICKS = 500,
   parameter int N_SHIFT    = 9
) (
   input logic           clk,
   input logic           rst_n,
   f1_sequencer_if.slave io_bus
);
   localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
   typedef enum logic [1:0] {IDLE, LIGHTS, HOLD, DONE} state_t;
   state_t        r_state, w_state;
   logic [6:0]    r_lfsr;
   logic [3:0]    r_step, w_step;
   logic [TW-1:0] r_tcnt, w_tcnt;
   logic [15:0]   r_n, w_n;
   logic [9:0]    r_ledr, w_ledr;
   logic          r_trigger, r_busy;
   // free-running x^7+x^6+1 LFSR, sampled on start to pick the hold count
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_lfsr <= 7'h01;
      else r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
   // next state, light step, tick counter and latched hold count
   always_comb begin
      w_state = r_state;
      w_step  = r_step;
      w_tcnt  = r_tcnt;
      w_n     = r_n;
      case (r_state)
         IDLE:
            if (io_bus.start) begin
               w_state = LIGHTS;
               w_n     = 16'({9'b0, r_lfsr} << N_SHIFT);
               w_step  = 4'd1;
               w_tcnt  = '0;
            end
         LIGHTS:
            if (io_bus.tick) begin
               if (r_tcnt == TW'(STEP_TICKS - 1)) begin
                  w_tcnt = '0;
                  if (r_step == 4'd10) w_state = HOLD;
                  else w_step = r_step + 4'd1;
               end else w_tcnt = r_tcnt + TW'(1);
            end
         HOLD:
            if (io_bus.time_out) w_state = DONE;
         DONE:
            if (!io_bus.start) w_state = IDLE;
         default: w_state = IDLE;
      endcase
   end
   // light pattern fills from the MSB; computed from the next state so outputs are registered
   always_comb
      w_ledr = (w_state == LIGHTS) ? ~(10'h3FF >> w_step) : (w_state == HOLD) ? 10'h3FF : 10'h000;
   // state and registered Moore outputs
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state   <= IDLE;
         r_step    <= '0;
         r_tcnt    <= '0;
         r_n       <= '0;
         r_ledr    <= '0;
         r_trigger <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_step    <= w_step;
         r_tcnt    <= w_tcnt;
         r_n       <= w_n;
         r_ledr    <= w_ledr;
         r_trigger <= (w_state == HOLD);
         r_busy    <= (w_state == LIGHTS) || (w_state == HOLD);
      end
   assign io_bus.ledr    = r_ledr;
   assign io_bus.trigger = r_trigger;
   assign io_bus.busy    = r_busy;
   assign io_bus.N       = r_n;
endmodule

// File: tb/tb_f1_sequencer.sv
// tb_f1_sequencer: directed and randomized checks of the start-light sequencer against a tick-count model
module tb_f1_sequencer;
   localparam int ST = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   pass_cnt = 0;
   int   total = 0;
   int   cyc = 0;
   f1_sequencer_if bus ();
   f1_sequencer #(.STEP_TICKS(ST), .N_SHIFT(9)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));
   always #5 clk = ~clk;
   // clock edges seen since the last reset release; the LFSR value is a function of this count
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else cyc <= cyc + 1;
   function automatic logic [6:0] lfsr_at(int e);
      logic [6:0] v = 7'h01;
      for (int i = 0; i < e % 127; i++) v = {v[5:0], v[6] ^ v[5]};
      return v;
   endfunction
   function automatic logic [9:0] lights(int k);
      logic [9:0] p = '0;
      for (int i = 0; i < k && i < 10; i++) p[9-i] = 1'b1;
      return p;
   endfunction
   function automatic logic [9:0] exp_ledr(int ticks);
      return (ticks < 10 * ST) ? lights(1 + ticks / ST) : 10'h3FF;
   endfunction
   task automatic finish_run();
      @(negedge clk); bus.time_out = 1'b1; bus.tick = 1'b0; bus.start = 1'b0;
      @(negedge clk); bus.time_out = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_reset();
      total++; if (bus.ledr !== 10'h0) $display("FAIL reset_ledr got %h expected 000", bus.ledr); else pass_cnt++;
      total++; if (bus.trigger !== 1'b0) $display("FAIL reset_trigger got %b expected 0", bus.trigger); else pass_cnt++;
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", bus.busy); else pass_cnt++;
      total++; if (bus.N !== 16'h0) $display("FAIL reset_N got %h expected 0000", bus.N); else pass_cnt++;
   endtask
   task automatic test_full_sequence();
      int e;
      int ticks = 0;
      logic [15:0] en;
      repeat ($urandom_range(1, 5)) @(negedge clk);
      bus.start = 1'b1; bus.tick = 1'b1; e = cyc;
      @(posedge clk); #1;
      en = {lfsr_at(e), 9'b0};
      total++; if (bus.busy !== 1'b1) $display("FAIL full_start_busy got %b expected 1", bus.busy); else pass_cnt++;
      total++; if (bus.ledr !== 10'h200) $display("FAIL full_start_ledr got %h expected 200", bus.ledr); else pass_cnt++;
      total++; if (bus.N !== en) $display("FAIL full_N got %h expected %h", bus.N, en); else pass_cnt++;
      total++; if (bus.N[8:0] !== 9'd0 || bus.N == 16'd0) $display("FAIL full_N_range got %h expected nonzero multiple of 512", bus.N); else pass_cnt++;
      for (int c = 0; c < 10 * ST; c++) begin
         @(negedge clk); bus.start = 1'b0; bus.tick = 1'b1;
         @(posedge clk); #1; ticks++;
         total++; if (bus.ledr !== exp_ledr(ticks)) $display("FAIL full_ledr t=%0d got %h expected %h", ticks, bus.ledr, exp_ledr(ticks)); else pass_cnt++;
         total++; if (bus.trigger !== (ticks >= 10 * ST)) $display("FAIL full_trigger t=%0d got %b expected %b", ticks, bus.trigger, ticks >= 10 * ST); else pass_cnt++;
         total++; if (bus.N !== en) $display("FAIL full_N_stable got %h expected %h", bus.N, en); else pass_cnt++;
      end
   endtask
   task automatic test_hold_button_held();
      int e;
      logic [15:0] en;
      repeat (3) begin
         @(negedge clk); bus.time_out = 1'b0; bus.tick = 1'b1;
         @(posedge clk); #1;
         total++; if (bus.trigger !== 1'b1 || bus.ledr !== 10'h3FF) $display("FAIL hold_wait got trig=%b ledr=%h expected trig=1 ledr=3ff", bus.trigger, bus.ledr); else pass_cnt++;
      end
      @(negedge clk); bus.time_out = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1;
      total++; if (bus.ledr !== 10'h0 || bus.trigger !== 1'b0 || bus.busy !== 1'b0) $display("FAIL hold_timeout got ledr=%h trig=%b busy=%b expected 000/0/0", bus.ledr, bus.trigger, bus.busy); else pass_cnt++;
      repeat (4) begin
         @(negedge clk); bus.time_out = 1'b0; bus.start = 1'b1;
         @(posedge clk); #1;
         total++; if (bus.busy !== 1'b0 || bus.ledr !== 10'h0) $display("FAIL done_held got busy=%b ledr=%h expected 0/000", bus.busy, bus.ledr); else pass_cnt++;
      end
      @(negedge clk); bus.start = 1'b0;
      @(posedge clk); #1;
      total++; if (bus.busy !== 1'b0) $display("FAIL done_release got busy=%b expected 0", bus.busy); else pass_cnt++;
      @(negedge clk); bus.start = 1'b1; e = cyc;
      @(posedge clk); #1;
      en = {lfsr_at(e), 9'b0};
      total++; if (bus.busy !== 1'b1 || bus.ledr !== 10'h200) $display("FAIL restart got busy=%b ledr=%h expected 1/200", bus.busy, bus.ledr); else pass_cnt++;
      total++; if (bus.N !== en) $display("FAIL restart_N got %h expected %h", bus.N, en); else pass_cnt++;
      @(negedge clk); bus.start = 1'b0;
   endtask
   task automatic test_reset_mid_run();
      repeat (3) @(negedge clk);
      @(posedge clk); #2; rst_n = 1'b0; #1;
      total++; if (bus.ledr !== 10'h0) $display("FAIL midreset_ledr got %h expected 000", bus.ledr); else pass_cnt++;
      total++; if (bus.busy !== 1'b0 || bus.trigger !== 1'b0) $display("FAIL midreset_ctl got busy=%b trig=%b expected 0/0", bus.busy, bus.trigger); else pass_cnt++;
      total++; if (bus.N !== 16'h0) $display("FAIL midreset_N got %h expected 0000", bus.N); else pass_cnt++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic test_ignored_inputs();
      int e;
      int ticks = 0;
      logic [15:0] en;
      @(negedge clk); bus.start = 1'b1; bus.tick = 1'b0; e = cyc;
      @(posedge clk); #1;
      en = {lfsr_at(e), 9'b0};
      total++; if (bus.N !== en) $display("FAIL ign_N got %h expected %h", bus.N, en); else pass_cnt++;
      while (ticks < 10 * ST) begin
         @(negedge clk); bus.tick = 1'b1; bus.time_out = 1'b1; bus.start = 1'($urandom_range(0, 1));
         @(posedge clk); #1; ticks++;
         total++; if (bus.ledr !== exp_ledr(ticks)) $display("FAIL ign_ledr t=%0d got %h expected %h", ticks, bus.ledr, exp_ledr(ticks)); else pass_cnt++;
         total++; if (bus.trigger !== (ticks >= 10 * ST) || bus.N !== en) $display("FAIL ign_trig t=%0d got trig=%b N=%h expected %b/%h", ticks, bus.trigger, bus.N, ticks >= 10 * ST, en); else pass_cnt++;
      end
      finish_run();
   endtask
   task automatic test_gapped_tick();
      int ticks = 0;
      int c = 0;
      bit t;
      @(negedge clk); bus.start = 1'b1; bus.tick = 1'b0;
      @(posedge clk); #1;
      while (ticks < 10 * ST) begin
         @(negedge clk); bus.start = 1'b0; t = (c % 5 == 4); bus.tick = t; c++;
         @(posedge clk); #1; if (t) ticks++;
         total++; if (bus.ledr !== exp_ledr(ticks) || bus.trigger !== (ticks >= 10 * ST)) $display("FAIL gap c=%0d got ledr=%h trig=%b expected %h/%b", c, bus.ledr, bus.trigger, exp_ledr(ticks), ticks >= 10 * ST); else pass_cnt++;
      end
      total++; if (c !== 50 * ST) $display("FAIL gap_len got %0d cycles expected %0d", c, 50 * ST); else pass_cnt++;
      finish_run();
   endtask
   task automatic test_random_runs();
      int e;
      int ticks;
      bit t;
      logic [15:0] en;
      for (int r = 0; r < 8; r++) begin
         repeat ($urandom_range(0, 9)) begin
            @(negedge clk); bus.start = 1'b0; bus.tick = 1'($urandom_range(0, 1)); bus.time_out = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            total++; if (bus.busy !== 1'b0 || bus.ledr !== 10'h0) $display("FAIL rnd_idle got busy=%b ledr=%h expected 0/000", bus.busy, bus.ledr); else pass_cnt++;
         end
         @(negedge clk); bus.start = 1'b1; bus.tick = 1'($urandom_range(0, 1)); bus.time_out = 1'($urandom_range(0, 1)); e = cyc;
         @(posedge clk); #1;
         en = {lfsr_at(e), 9'b0}; ticks = 0;
         total++; if (bus.N !== en || bus.ledr !== 10'h200) $display("FAIL rnd_start got N=%h ledr=%h expected %h/200", bus.N, bus.ledr, en); else pass_cnt++;
         while (ticks < 10 * ST) begin
            @(negedge clk); t = ($urandom_range(0, 2) == 0); bus.tick = t;
            bus.start = 1'($urandom_range(0, 1)); bus.time_out = 1'($urandom_range(0, 1));
            @(posedge clk); #1; if (t) ticks++;
            total++; if (bus.ledr !== exp_ledr(ticks) || bus.trigger !== (ticks >= 10 * ST) || bus.N !== en) $display("FAIL rnd_lights t=%0d got ledr=%h trig=%b N=%h expected %h/%b/%h", ticks, bus.ledr, bus.trigger, bus.N, exp_ledr(ticks), ticks >= 10 * ST, en); else pass_cnt++;
         end
         repeat ($urandom_range(0, 5)) begin
            @(negedge clk); bus.time_out = 1'b0; bus.tick = 1'($urandom_range(0, 1)); bus.start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            total++; if (bus.trigger !== 1'b1 || bus.ledr !== 10'h3FF || bus.busy !== 1'b1) $display("FAIL rnd_hold got trig=%b ledr=%h busy=%b expected 1/3ff/1", bus.trigger, bus.ledr, bus.busy); else pass_cnt++;
         end
         @(negedge clk); bus.time_out = 1'b1; bus.tick = 1'b1; bus.start = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         total++; if (bus.trigger !== 1'b0 || bus.ledr !== 10'h0 || bus.busy !== 1'b0) $display("FAIL rnd_timeout got trig=%b ledr=%h busy=%b expected 0/000/0", bus.trigger, bus.ledr, bus.busy); else pass_cnt++;
         repeat ($urandom_range(0, 4)) begin
            @(negedge clk); bus.time_out = 1'b0; bus.start = 1'b1;
            @(posedge clk); #1;
            total++; if (bus.busy !== 1'b0) $display("FAIL rnd_done got busy=%b expected 0", bus.busy); else pass_cnt++;
         end
         @(negedge clk); bus.time_out = 1'b0; bus.start = 1'b0;
         @(posedge clk); #1;
      end
   endtask
   initial begin
      bus.tick = 1'b0; bus.start = 1'b0; bus.time_out = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      test_reset();
      test_full_sequence();
      test_hold_button_held();
      test_reset_mid_run();
      test_ignored_inputs();
      test_gapped_tick();
      test_random_runs();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
